prbs10_checker: RTL and testbench
=================================

Name: prbs10_checker

Overview:
Serial PRBS checker that receives the bit stream produced by the team's 10-bit LFSR generator (lfsr10, polynomial x^10 + x^7 + 1).
- Self-synchronises to the incoming stream, declares lock, and then compares each received bit against a locally regenerated reference.
- Counts bit errors and drops lock when the error density is too high.
- Sits at the receive end of the PRBS link-test path, clocked in the generator's clock domain.

Parameters:
LOCK_COUNT, 16, consecutive correct predictions required in SYNC before declaring lock (range 1..255).
WINDOW, 64, valid bits per error-density window in LOCKED (range 2..1024).
UNLOCK_ERRS, 8, errors within one window that force loss of lock (range 1..WINDOW).
CNT_W, 16, width of the error and bit counters.

Ports:
clock  input  1  single system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  1  received serial PRBS bit.
data_valid  input  1  data_in is sampled only on cycles where this is 1.
clr_count  input  1  synchronous clear of err_count and bit_count.
locked  output  1  1 while the checker is in LOCKED.
error  output  1  one-cycle pulse for each mismatched bit while in LOCKED.
err_count  output  CNT_W  saturating count of mismatches while in LOCKED.
bit_count  output  CNT_W  saturating count of bits checked while in LOCKED.

Behaviour:
- Reset: state=SEED, hist=0, seed/match/window counters=0, locked=0, error=0, err_count=0, bit_count=0. Reset overrides all other inputs, including a reset asserted mid-stream or while LOCKED.
- hist is a 10-bit history; hist[0] is the newest bit. pred = hist[9] ^ hist[6]. This is exactly the recurrence b(n) = b(n-10) ^ b(n-7) of the generator.
- When data_valid=0, nothing changes except that clr_count still takes effect and error is 0.
- SEED state:
  - Each valid bit shifts into hist.
  - After 10 valid bits, go to SYNC with match counter=0.
- SYNC state:
  - Each valid bit is compared with pred, then data_in shifts into hist.
  - If the bit matches and the shifted hist is nonzero, increment the match counter.
  - A mismatch resets the match counter to 0 and the state stays SYNC; re-seeding is not needed because hist holds real data.
  - If the shifted hist is all-zero, reset the match counter to 0. An all-zero stream never locks.
  - When the match counter reaches LOCK_COUNT, go to LOCKED and clear the window counters. locked rises on the clock edge that samples the LOCK_COUNT-th matching bit.
- LOCKED state:
  - Each valid bit is compared with pred, and pred (not data_in) shifts into hist. The reference free-runs, so a single flipped input bit produces exactly one error.
  - On a mismatch: error=1 in the cycle after the sampling edge (registered, latency 1). err_count increments, saturating at 2^CNT_W-1. The window error counter increments.
  - bit_count increments on every valid bit, saturating at 2^CNT_W-1.
  - The window bit counter increments per valid bit. When it reaches WINDOW, both window counters clear.
  - If the window error count reaches UNLOCK_ERRS: go to SEED, hist=0, and locked falls on that same edge. That bit's error pulse is still issued and counted.
- Simultaneous events:
  - clr_count together with a counting event: the clear wins, and the counter becomes 0, not 1.
  - Window wrap and the UNLOCK_ERRS-th error on the same bit: unlock takes priority.
- err_count and bit_count hold their values across loss of lock. Only reset or clr_count clears them.
- No combinational path from any input to any output.

Test Plan:
- Reset, then feed a continuous lfsr10 stream (seed 10'b0000000001, data_valid=1) → locked=0 through bit 25; locked=1 after the edge sampling bit 26 (10 seed + 16 matches); err_count=0 and bit_count=74 after 100 bits.
- While locked, invert only bit 50 of the stream → exactly one error pulse, one cycle after that bit; err_count=1; locked stays 1; no further errors over the next 200 bits.
- While locked, invert 8 bits within one 64-bit window → error pulses 1..8; locked=0 on the 8th; state=SEED; the checker relocks 26 valid bits later; err_count=8.
- Drive data_in=0 constantly with data_valid=1 for 200 cycles → locked never asserts; err_count=0.
- Toggle data_valid 1/0 each cycle on a valid lfsr10 stream → lock after 26 valid bits (about 52 cycles); no errors; bits on invalid cycles are ignored.
- Assert reset for one cycle while locked with err_count=3 → next cycle locked=0, err_count=0, bit_count=0; relock 26 bits later. Assert clr_count on the same cycle as an error → err_count=0.

Source files
------------

// File: rtl/prbs10_checker.sv
// Serial checker for the lfsr10 PRBS stream (x^10 + x^7 + 1).
// Self-synchronises, locks, then counts errors against a free-running reference.
module prbs10_checker #(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned WIN_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {StSeed, StSync, StLocked} state_e;

    state_e           state;
    logic [9:0]       hist;
    logic [3:0]       seed_cnt;
    logic [7:0]       match_cnt;
    logic [WIN_W-1:0] win_bits;
    logic [WIN_W-1:0] win_errs;

    logic             pred;
    logic             mism;
    logic [9:0]       hist_rx;
    logic [WIN_W-1:0] win_bits_inc;
    logic [WIN_W-1:0] win_errs_inc;
    logic             err_sat;
    logic             bit_sat;

    // hist[9] is b(n-10), hist[6] is b(n-7) relative to the incoming bit.
    assign pred         = hist[9] ^ hist[6];
    assign mism         = data_in ^ pred;
    assign hist_rx      = {hist[8:0], data_in};
    assign win_bits_inc = win_bits + 1'b1;
    assign win_errs_inc = win_errs + WIN_W'(mism);
    assign err_sat      = &err_count;
    assign bit_sat      = &bit_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StSeed;
            hist      <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                unique case (state)
                    StSeed: begin
                        hist <= hist_rx;
                        if (seed_cnt == 4'd9) begin
                            state     <= StSync;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + 4'd1;
                        end
                    end
                    StSync: begin
                        hist <= hist_rx;
                        // An all-zero history trivially predicts zeros; never count it.
                        if (!mism && (hist_rx != '0)) begin
                            if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                                state     <= StLocked;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                win_bits  <= '0;
                                win_errs  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    StLocked: begin
                        // Reference free-runs so one flipped bit yields one error.
                        hist  <= {hist[8:0], pred};
                        error <= mism;
                        if (!bit_sat) begin
                            bit_count <= bit_count + 1'b1;
                        end
                        if (mism && !err_sat) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (mism && (win_errs_inc == WIN_W'(UNLOCK_ERRS))) begin
                            state    <= StSeed;
                            locked   <= 1'b0;
                            hist     <= '0;
                            seed_cnt <= '0;
                            win_bits <= '0;
                            win_errs <= '0;
                        end else if (win_bits_inc == WIN_W'(WINDOW)) begin
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            win_bits <= win_bits_inc;
                            win_errs <= win_errs_inc;
                        end
                    end
                    default: begin
                        state  <= StSeed;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clr_count) begin
                err_count <= '0;
                bit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs10_checker.sv
// Randomised self-checking bench for prbs10_checker against a queue-based model.
module tb_prbs10_checker;

    localparam int unsigned LC    = 16;
    localparam int unsigned WIN   = 64;
    localparam int unsigned UNL   = 8;
    localparam int unsigned CW    = 16;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam int          SLEN  = 16384;

    logic          clock;
    logic          reset;
    logic          data_in;
    logic          data_valid;
    logic          clr_count;
    logic          locked;
    logic          error;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    prbs10_checker #(
        .LOCK_COUNT (LC),
        .WINDOW     (WIN),
        .UNLOCK_ERRS(UNL),
        .CNT_W      (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .clr_count (clr_count),
        .locked    (locked),
        .error     (error),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference stream: b(n) = b(n-10) ^ b(n-7), seeded 10'b0000000001.
    bit gs[SLEN];
    int sidx = 0;

    // Model: mode 0 seeding, 1 hunting, 2 locked; hq holds last bits, oldest first.
    int m_mode, m_match, m_wb, m_we, m_ec, m_bc;
    bit m_err;
    bit hq[$];

    function automatic bit hq_any();
        foreach (hq[i]) if (hq[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model(input bit din, input bit dv, input bit clr, input bit rst);
        bit p;
        if (rst) begin
            m_mode = 0; hq.delete(); m_match = 0; m_wb = 0; m_we = 0;
            m_ec = 0; m_bc = 0; m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (dv) begin
            case (m_mode)
                0: begin
                    hq.push_back(din);
                    if (hq.size() == 10) begin
                        m_mode = 1; m_match = 0;
                    end
                end
                1: begin
                    p = hq[0] ^ hq[3];
                    hq.push_back(din);
                    void'(hq.pop_front());
                    if (din == p && hq_any()) m_match++;
                    else m_match = 0;
                    if (m_match == LC) begin
                        m_mode = 2; m_wb = 0; m_we = 0;
                    end
                end
                default: begin
                    p = hq[0] ^ hq[3];
                    m_err = (din != p);
                    hq.push_back(p);
                    void'(hq.pop_front());
                    if (m_bc < CMAX) m_bc++;
                    if (m_err) begin
                        if (m_ec < CMAX) m_ec++;
                        m_we++;
                    end
                    if (m_err && m_we == UNL) begin
                        m_mode = 0; hq.delete();
                    end else begin
                        m_wb++;
                        if (m_wb == WIN) begin
                            m_wb = 0; m_we = 0;
                        end
                    end
                end
            endcase
        end
        if (clr) begin
            m_ec = 0; m_bc = 0;
        end
    endtask

    task automatic step(input bit din, input bit dv, input bit clr, input bit rst);
        data_in = din; data_valid = dv; clr_count = clr; reset = rst;
        @(posedge clock);
        #1;
        model(din, dv, clr, rst);
        check("locked", {31'b0, locked}, {31'b0, m_mode == 2});
        check("error", {31'b0, error}, {31'b0, m_err});
        check("err_count", 32'(err_count), 32'(m_ec));
        check("bit_count", 32'(bit_count), 32'(m_bc));
    endtask

    task automatic send(input bit flip, input bit clr);
        step(gs[sidx] ^ flip, 1'b1, clr, 1'b0);
        sidx++;
    endtask

    initial begin
        int pulses;
        bit lk;
        for (int n = 0; n < SLEN; n++) begin
            if (n < 10) gs[n] = (n == 0);
            else gs[n] = gs[n-10] ^ gs[n-7];
        end
        data_in = 1'b0; data_valid = 1'b0; clr_count = 1'b0; reset = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_locked", {31'b0, locked}, 0);
        check("rst_err_count", 32'(err_count), 0);

        // Clean stream: lock on the 26th bit
        for (int i = 1; i <= 100; i++) begin
            send(1'b0, 1'b0);
            if (i == 25) check("lock_at_25", {31'b0, locked}, 0);
            if (i == 26) check("lock_at_26", {31'b0, locked}, 1);
        end
        check("bit_count_100", 32'(bit_count), 74);
        check("err_count_100", 32'(err_count), 0);

        // Single inverted bit
        pulses = 0;
        send(1'b1, 1'b0);
        pulses += int'(error);
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 1'b0);
            pulses += int'(error);
        end
        check("single_pulses", 32'(pulses), 1);
        check("single_err_count", 32'(err_count), 1);
        check("single_locked", {31'b0, locked}, 1);

        // Burst of UNLOCK_ERRS errors inside one window
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2 * WIN && m_wb != 0; k++) send(1'b0, 1'b0);
        for (int j = 1; j <= UNL; j++) begin
            send(1'b1, 1'b0);
            check("burst_pulse", {31'b0, error}, 1);
            if (j == UNL - 1) check("burst_still_locked", {31'b0, locked}, 1);
        end
        check("burst_unlocked", {31'b0, locked}, 0);
        check("burst_err_count", 32'(err_count), UNL);
        for (int i = 1; i <= 26; i++) begin
            send(1'b0, 1'b0);
            if (i == 25) check("relock_25", {31'b0, locked}, 0);
        end
        check("relock_26", {31'b0, locked}, 1);

        // All-zero stream never locks
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lk = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            lk |= locked;
        end
        check("zeros_never_lock", {31'b0, lk}, 0);
        check("zeros_err_count", 32'(err_count), 0);

        // Alternating data_valid with junk on idle cycles
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 26; i++) begin
            step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b0);
            if (i == 25) check("gap_lock_25", {31'b0, locked}, 0);
        end
        check("gap_lock_26", {31'b0, locked}, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b0);
        end
        check("gap_no_errors", 32'(err_count), 0);

        // Three errors, then reset while locked
        for (int j = 0; j < 3; j++) begin
            send(1'b1, 1'b0);
            repeat (4) send(1'b0, 1'b0);
        end
        check("three_errs", 32'(err_count), 3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_mid_locked", {31'b0, locked}, 0);
        check("rst_mid_err", 32'(err_count), 0);
        check("rst_mid_bits", 32'(bit_count), 0);
        for (int i = 1; i <= 26; i++) begin
            send(1'b0, 1'b0);
            if (i == 25) check("rst_relock_25", {31'b0, locked}, 0);
        end
        check("rst_relock_26", {31'b0, locked}, 1);
        send(1'b1, 1'b1);
        check("clr_vs_err_pulse", {31'b0, error}, 1);
        check("clr_vs_err_count", 32'(err_count), 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            bit dv, fl, cl, rs;
            dv = ($urandom_range(3) != 0);
            fl = ($urandom_range(49) == 0);
            cl = ($urandom_range(299) == 0);
            rs = ($urandom_range(1499) == 0);
            if (dv) begin
                step(gs[sidx] ^ fl, 1'b1, cl, rs);
                sidx++;
            end else begin
                step(1'($urandom_range(1)), 1'b0, cl, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
